// File: rtl/sync_ff_chain.sv
// N-stage flip-flop synchroniser for an asynchronous single-bit input.
// Stages are plain back-to-back flops so metastability has full cycles to resolve.
module sync_ff_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_stages;

    always_ff @(posedge clk) begin
        if (rst) r_stages <= '0;
        else     r_stages <= {r_stages[N-2:0], i_d};
    end

    assign o_q = r_stages[N-1];

endmodule

// File: rtl/antirebote_debounce.sv
// Button conditioner: synchronise, require a stable level, then emit either a
// one-cycle press pulse or the registered debounced level.
module antirebote_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3,
    parameter int PULSE_MODE    = 1
) (
    input  logic bot,
    input  logic clk,
    input  logic rst,
    output logic Y
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_s;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_y;

    sync_ff_chain #(.N(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bot),
        .o_q (w_s)
    );

    // Count consecutive samples disagreeing with db; any agreeing sample restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (w_s != r_db) begin
            if (r_cnt == CNT_LAST) begin
                r_db  <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    generate
        if (PULSE_MODE != 0) begin : g_pulse
            logic r_db_prev;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_db_prev <= 1'b0;
                    r_y       <= 1'b0;
                end else begin
                    r_db_prev <= r_db;
                    r_y       <= r_db & ~r_db_prev;
                end
            end
        end else begin : g_level
            always_ff @(posedge clk) begin
                if (rst) r_y <= 1'b0;
                else     r_y <= r_db;
            end
        end
    endgenerate

    assign Y = r_y;

endmodule

// File: tb/tb_antirebote_debounce.sv
// Bench for antirebote_debounce: pulse-mode and level-mode instances share stimulus,
// checked by vector table, hand sequences and a history-based reference model.
module tb_antirebote_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bot = 1'b0;
    logic yp, yl;

    always #5 clk = ~clk;

    antirebote_debounce #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .PULSE_MODE(1)) u_pulse (
        .bot (bot), .clk (clk), .rst (rst), .Y (yp)
    );
    antirebote_debounce #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .PULSE_MODE(0)) u_level (
        .bot (bot), .clk (clk), .rst (rst), .Y (yl)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference model: s is bot delayed SYNC edges; db flips to the opposite
    // level once the last STABLE samples since reset all disagree with it.
    bit m_sync [SYNC];
    bit s_hist [$];
    bit m_s, m_all, m_db, m_prev, m_yp, m_yl;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_sync[i]) m_sync[i] = 1'b0;
            s_hist.delete();
            m_db = 0; m_prev = 0; m_yp = 0; m_yl = 0;
        end else begin
            m_s = m_sync[SYNC-1];
            for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = bot;
            m_yp   = m_db & ~m_prev;
            m_yl   = m_db;
            m_prev = m_db;
            s_hist.push_back(m_s);
            if (s_hist.size() > STABLE) void'(s_hist.pop_front());
            if (s_hist.size() == STABLE) begin
                m_all = 1'b1;
                foreach (s_hist[i]) if (s_hist[i] == m_db) m_all = 1'b0;
                if (m_all) m_db = ~m_db;
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pulse", yp, m_yp);
            chk("model_level", yl, m_yl);
        end
    end

    typedef struct {
        logic rst;
        logic bot;
        logic yp;
        logic yl;
    } vec_t;

    vec_t tbl [31];
    int   bcnt;

    task automatic step(input logic r, input logic b);
        rst = r;
        bot = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset with button held, clean press, release, then a 2-cycle glitch.
        for (int i = 0; i < 31; i++) begin
            tbl[i].rst = (i < 3);
            tbl[i].bot = (i < 13) || (i == 21) || (i == 22);
            tbl[i].yp  = (i == 8);
            tbl[i].yl  = (i >= 8) && (i <= 17);
        end

        @(negedge clk);
        for (int i = 0; i < 31; i++) begin
            step(tbl[i].rst, tbl[i].bot);
            if (i == 0) chk_en = 1'b1;
            chk($sformatf("tbl%0d_pulse", i), yp, tbl[i].yp);
            chk($sformatf("tbl%0d_level", i), yl, tbl[i].yl);
        end

        // Reset three cycles after press discards the partial count.
        repeat (6) step(1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            step(i == 3, 1'b1);
            chk($sformatf("rstmid%0d_pulse", i), yp, (i == 9));
        end
        repeat (10) step(1'b0, 1'b0);

        // Bounce at 1.5 clock periods, then settle high.
        bcnt = 0;
        fork
            begin
                #2 bot = ~bot;
                repeat (13) #15 bot = ~bot;
                #15 bot = 1'b1;
            end
            begin
                repeat (21) begin
                    @(negedge clk);
                    if (yp === 1'b1) bcnt++;
                end
            end
        join
        chk("bounce_no_pulse", (bcnt == 0), 1'b1);
        bcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (yp === 1'b1) bcnt++;
        end
        chk("bounce_one_pulse", (bcnt == 1), 1'b1);
        repeat (8) step(1'b0, 1'b0);

        // Random runs of varying length with occasional resets.
        repeat (80) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++)
                step(($urandom_range(0, 31) == 0), v);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
